// File: rtl/gmii_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_sched
// Description : Frame-by-frame scheduler choosing video, video+audio (vidax) or
//               audio-only UDP frames for the GMII transmitter.
// Revision    : 1.0  initial release
// ============================================================================
module gmii_tx_sched #(
    parameter int AUDIOMAX    = 20,
    parameter int VIDAX_MAX   = 8,
    parameter int AUX_BYTES   = 34,
    parameter int AUD_THRESH  = 4,
    parameter int AUD_TIMEOUT = 2000,
    parameter int DONE_TMO    = 4095
) (
    input  logic        tx_clk,
    input  logic        sys_rst,
    input  logic        vid_ready,
    input  logic        ade_strobe,
    input  logic        req_ready,
    input  logic        tx_done,
    output logic        req_valid,
    output logic [1:0]  req_type,
    output logic [4:0]  req_ade,
    output logic [11:0] req_len,
    output logic [4:0]  pending,
    output logic        aud_ovf,
    output logic        done_err
);

    localparam logic [1:0]  c_type_video = 2'b00;
    localparam logic [1:0]  c_type_audio = 2'b01;
    localparam logic [1:0]  c_type_vidax = 2'b10;
    localparam logic [4:0]  c_audiomax   = 5'(AUDIOMAX);
    localparam logic [4:0]  c_vidax_max  = 5'(VIDAX_MAX);
    localparam logic [4:0]  c_aud_thresh = 5'(AUD_THRESH);
    localparam logic [15:0] c_aud_tmo    = 16'(AUD_TIMEOUT);
    localparam logic [11:0] c_aux_bytes  = 12'(AUX_BYTES);
    localparam logic [11:0] c_done_last  = 12'(DONE_TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [15:0]  r_age;
    logic [11:0]  r_timer;

    logic         w_sel_valid;
    logic [1:0]   w_sel_type;
    logic [4:0]   w_sel_ade;
    logic [11:0]  w_sel_len;
    logic         w_accept;
    logic         w_load;
    logic [4:0]   w_pend_sum;
    logic [4:0]   w_pend_next;

    // Frame selection, shared by IDLE and by WAIT_DONE on tx_done so a new
    // request can be registered in the same edge that retires the old frame.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_type  = c_type_video;
        w_sel_ade   = 5'd0;
        if (vid_ready) begin
            w_sel_valid = 1'b1;
            if (pending != 5'd0) begin
                w_sel_type = c_type_vidax;
                w_sel_ade  = (pending > c_vidax_max) ? c_vidax_max : pending;
            end
        end else if ((pending != 5'd0) &&
                     ((pending >= c_aud_thresh) || (r_age >= c_aud_tmo))) begin
            w_sel_valid = 1'b1;
            w_sel_type  = c_type_audio;
            w_sel_ade   = (pending > c_audiomax) ? c_audiomax : pending;
        end
    end

    assign w_sel_len   = c_aux_bytes * {7'd0, w_sel_ade};
    assign w_accept    = req_valid & req_ready;
    assign w_load      = w_sel_valid &&
                         ((r_state == ST_IDLE) || ((r_state == ST_WAIT_DONE) && tx_done));
    assign w_pend_sum  = (pending == 5'd31) ? 5'd31 : pending + {4'd0, ade_strobe};
    assign w_pend_next = w_pend_sum - (w_accept ? req_ade : 5'd0);

    always_ff @(posedge tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_age     <= 16'd0;
            r_timer   <= 12'd0;
            req_valid <= 1'b0;
            req_type  <= c_type_video;
            req_ade   <= 5'd0;
            req_len   <= 12'd0;
            pending   <= 5'd0;
            aud_ovf   <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            done_err <= 1'b0;
            pending  <= w_pend_next;
            if (ade_strobe && (pending == 5'd31) && !w_accept)
                aud_ovf <= 1'b1;

            if ((w_accept && (req_type != c_type_video)) || (pending == 5'd0))
                r_age <= 16'd0;
            else if (r_age != 16'hFFFF)
                r_age <= r_age + 16'd1;

            if (w_load) begin
                req_valid <= 1'b1;
                req_type  <= w_sel_type;
                req_ade   <= w_sel_ade;
                req_len   <= w_sel_len;
                r_state   <= ST_REQ;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_REQ: begin
                        if (req_ready) begin
                            req_valid <= 1'b0;
                            r_timer   <= 12'd0;
                            r_state   <= ST_WAIT_DONE;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (tx_done) begin
                            r_state <= ST_IDLE;
                        end else if (r_timer == c_done_last) begin
                            done_err <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_timer <= r_timer + 12'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_sched.sv
`default_nettype none
// Testbench for gmii_tx_sched: table of single-frame vectors plus multi-cycle
// sequences; granted requests are compared against a queue of expected frames.
module tb_gmii_tx_sched;

    logic        tx_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        vid_ready = 1'b0;
    logic        ade_strobe = 1'b0;
    logic        req_ready = 1'b0;
    logic        tx_done = 1'b0;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [4:0]  req_ade;
    logic [11:0] req_len;
    logic [4:0]  pending;
    logic        aud_ovf;
    logic        done_err;

    gmii_tx_sched dut (
        .tx_clk    (tx_clk),
        .sys_rst   (sys_rst),
        .vid_ready (vid_ready),
        .ade_strobe(ade_strobe),
        .req_ready (req_ready),
        .tx_done   (tx_done),
        .req_valid (req_valid),
        .req_type  (req_type),
        .req_ade   (req_ade),
        .req_len   (req_len),
        .pending   (pending),
        .aud_ovf   (aud_ovf),
        .done_err  (done_err)
    );

    always #4 tx_clk = ~tx_clk;

    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  ade;
        logic [11:0] len;
    } frame_t;

    typedef struct {
        logic        vid;
        int          nstr;
        logic [1:0]  typ;
        logic [4:0]  ade;
        logic [11:0] len;
        logic [4:0]  pend_after;
    } vec_t;

    frame_t sb_q[$];
    vec_t   vecs[5];
    int     checks = 0;
    int     failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [4:0] a, input logic [11:0] l);
        frame_t f;
        f.typ = t; f.ade = a; f.len = l;
        sb_q.push_back(f);
    endtask

    task automatic strobe(input int n);
        ade_strobe = 1'b1;
        repeat (n) tick();
        ade_strobe = 1'b0;
    endtask

    task automatic accept();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int bound);
        int n = 0;
        while (!req_valid && n < bound) begin
            tick();
            n++;
        end
        chk(nm, int'(req_valid), 1);
    endtask

    // Every accepted request is compared to the oldest expected frame.
    always @(negedge tx_clk) begin
        if (!sys_rst && req_valid && req_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_req", 1, 0);
            end else begin
                frame_t f;
                f = sb_q.pop_front();
                chk("sb_req_type", int'(req_type), int'(f.typ));
                chk("sb_req_ade", int'(req_ade), int'(f.ade));
                chk("sb_req_len", int'(req_len), int'(f.len));
            end
        end
    end

    initial begin
        bit saw;
        int n;

        vecs[0] = '{vid: 1'b1, nstr: 0, typ: 2'b00, ade: 5'd0, len: 12'd0,   pend_after: 5'd0};
        vecs[1] = '{vid: 1'b1, nstr: 3, typ: 2'b10, ade: 5'd3, len: 12'd102, pend_after: 5'd0};
        vecs[2] = '{vid: 1'b1, nstr: 1, typ: 2'b10, ade: 5'd1, len: 12'd34,  pend_after: 5'd0};
        vecs[3] = '{vid: 1'b0, nstr: 4, typ: 2'b01, ade: 5'd4, len: 12'd136, pend_after: 5'd0};
        vecs[4] = '{vid: 1'b1, nstr: 2, typ: 2'b10, ade: 5'd2, len: 12'd68,  pend_after: 5'd0};

        // Reset state
        repeat (2) @(posedge tx_clk);
        #1;
        chk("rst_req_valid", int'(req_valid), 0);
        chk("rst_req_type", int'(req_type), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_aud_ovf", int'(aud_ovf), 0);
        chk("rst_done_err", int'(done_err), 0);
        sys_rst = 1'b0;
        tick();

        // Video with req_ready already high; next request right after tx_done
        vid_ready = 1'b1;
        req_ready = 1'b1;
        push(2'b00, 5'd0, 12'd0);
        wait_valid("t1_valid", 10);
        tick();
        chk("t1_valid_one_cycle", int'(req_valid), 0);
        saw = 1'b0;
        repeat (1300) begin
            tick();
            if (done_err) saw = 1'b1;
        end
        chk("t1_no_done_err", int'(saw), 0);
        push(2'b00, 5'd0, 12'd0);
        pulse_done();
        chk("t1_next_req_after_done", int'(req_valid), 1);
        vid_ready = 1'b0;
        tick();
        chk("t1_second_accepted", int'(req_valid), 0);
        req_ready = 1'b0;
        pulse_done();

        // Table of single-frame vectors
        for (int i = 0; i < 5; i++) begin
            req_ready = 1'b0;
            vid_ready = 1'b0;
            strobe(vecs[i].nstr);
            vid_ready = vecs[i].vid;
            push(vecs[i].typ, vecs[i].ade, vecs[i].len);
            wait_valid($sformatf("vec%0d_valid", i), 20);
            repeat (2) tick();
            chk($sformatf("vec%0d_held", i), int'(req_valid), 1);
            accept();
            chk($sformatf("vec%0d_valid_drop", i), int'(req_valid), 0);
            chk($sformatf("vec%0d_pending", i), int'(pending), int'(vecs[i].pend_after));
            vid_ready = 1'b0;
            repeat (5) tick();
            pulse_done();
            tick();
            chk($sformatf("vec%0d_idle", i), int'(req_valid), 0);
        end

        // 25 pending: audio capped at AUDIOMAX, remainder follows
        vid_ready = 1'b1;
        push(2'b00, 5'd0, 12'd0);
        wait_valid("t3_video_valid", 10);
        accept();
        vid_ready = 1'b0;
        strobe(25);
        chk("t3_pending25", int'(pending), 25);
        push(2'b01, 5'd20, 12'd680);
        pulse_done();
        chk("t3_audio20_valid", int'(req_valid), 1);
        accept();
        chk("t3_pending5", int'(pending), 5);
        push(2'b01, 5'd5, 12'd170);
        pulse_done();
        chk("t3_audio5_valid", int'(req_valid), 1);
        accept();
        chk("t3_pending0", int'(pending), 0);
        pulse_done();

        // Age timeout forces an audio frame for a single ADE
        push(2'b01, 5'd1, 12'd34);
        strobe(1);
        n = 0;
        while (!req_valid && n < 2100) begin
            tick();
            n++;
        end
        chk("t4_timeout_window", int'(n >= 1995 && n <= 2005), 1);
        accept();
        chk("t4_pending0", int'(pending), 0);
        pulse_done();

        // Strobe coincident with accept, then saturation/overflow
        strobe(2);
        push(2'b10, 5'd2, 12'd68);
        vid_ready = 1'b1;
        wait_valid("t5_vidax_valid", 10);
        vid_ready = 1'b0;
        req_ready = 1'b1;
        ade_strobe = 1'b1;
        tick();
        req_ready = 1'b0;
        ade_strobe = 1'b0;
        chk("t5_pending_strobe_accept", int'(pending), 1);
        pulse_done();
        push(2'b01, 5'd4, 12'd136);
        strobe(32);
        chk("t5_pending_sat", int'(pending), 31);
        chk("t5_aud_ovf", int'(aud_ovf), 1);
        chk("t5_audio_valid", int'(req_valid), 1);
        accept();
        chk("t5_pending27", int'(pending), 27);

        // tx_done watchdog, then async reset mid-frame
        push(2'b01, 5'd20, 12'd680);
        n = 0;
        while (!done_err && n < 4200) begin
            tick();
            n++;
        end
        chk("t6_done_tmo_window", int'(n >= 4090 && n <= 4100), 1);
        tick();
        chk("t6_done_err_pulse", int'(done_err), 0);
        chk("t6_req_after_tmo", int'(req_valid), 1);
        accept();
        chk("t6_pending7", int'(pending), 7);
        tick();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t6_arst_req_type", int'(req_type), 0);
        chk("t6_arst_req_ade", int'(req_ade), 0);
        chk("t6_arst_req_len", int'(req_len), 0);
        chk("t6_arst_pending", int'(pending), 0);
        chk("t6_arst_aud_ovf", int'(aud_ovf), 0);
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        chk("sb_all_consumed", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
